// File: rtl/fc2_bias_add.sv
// fc2_bias_add: FC2 bias consumer. Steps the bias ROM reader with one-cycle
// read-enable pulses, captures each bias word after the ROM latency, adds it
// to the matching accumulator word, then requantises and saturates to int8.
module fc2_bias_add #(
    parameter int NUM_OUT    = 10,
    parameter int ACC_W      = 24,
    parameter int ROM_LAT    = 1,
    parameter int BIAS_SHIFT = 4,
    parameter int OUT_SHIFT  = 8,
    parameter int RELU       = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    bias_en,
    input  logic signed [7:0]       bias_data,
    input  logic                    acc_valid,
    input  logic signed [ACC_W-1:0] acc_data,
    output logic                    acc_ready,
    output logic                    out_valid,
    output logic signed [7:0]       out_data,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_ACC, S_OUT} state_t;

    localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int LAT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    // Wide enough that neither the accumulator nor the shifted bias can overflow
    localparam int SUM_W = (ACC_W + 9 > BIAS_SHIFT + 9) ? ACC_W + 9 : BIAS_SHIFT + 9;

    localparam logic [IDX_W-1:0]        LAST_IDX  = IDX_W'(NUM_OUT - 1);
    localparam logic [LAT_W-1:0]        LAST_WAIT = LAT_W'(ROM_LAT - 1);
    localparam logic signed [SUM_W-1:0] SAT_MAX   = SUM_W'(127);
    localparam logic signed [SUM_W-1:0] SAT_MIN   = SUM_W'(-128);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [LAT_W-1:0]   wcnt_q;
    logic signed [7:0]  bias_q;
    logic               bias_en_d, acc_ready_d, out_valid_d, busy_d, done_d;
    logic signed [SUM_W-1:0] acc_x, bias_x, sum, q;
    logic signed [7:0]  res;

    wire acc_fire  = (state_q == S_ACC) && acc_valid;
    wire out_fire  = (state_q == S_OUT) && out_ready;
    wire last_idx  = (idx_q == LAST_IDX);
    wire wait_last = (state_q == S_WAIT) && (wcnt_q == LAST_WAIT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: one enable pulse per neuron, never re-issued
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: state_d = S_WAIT;
            S_WAIT:  if (wait_last) state_d = S_ACC;
            S_ACC:   if (acc_fire) state_d = S_OUT;
            S_OUT:   if (out_fire) state_d = last_idx ? S_IDLE : S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so every output leaves a flop
    always_comb begin
        bias_en_d   = (state_d == S_FETCH);
        acc_ready_d = (state_d == S_ACC);
        out_valid_d = (state_d == S_OUT);
        busy_d      = (state_d != S_IDLE);
        done_d      = out_fire && last_idx;
    end

    // Registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_en   <= 1'b0;
            acc_ready <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            bias_en   <= bias_en_d;
            acc_ready <= acc_ready_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // Bias add, floor shift, optional ReLU, int8 saturation
    always_comb begin
        acc_x  = {{(SUM_W-ACC_W){acc_data[ACC_W-1]}}, acc_data};
        bias_x = {{(SUM_W-8){bias_q[7]}}, bias_q} <<< BIAS_SHIFT;
        sum    = acc_x + bias_x;
        q      = sum >>> OUT_SHIFT;
        if (RELU != 0 && q < 0) q = '0;
        if (q > SAT_MAX)      res = 8'sd127;
        else if (q < SAT_MIN) res = -8'sd128;
        else                  res = q[7:0];
    end

    // Neuron index, ROM latency counter, bias capture and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            wcnt_q   <= '0;
            bias_q   <= '0;
            out_data <= '0;
        end else begin
            if (state_q == S_IDLE)  idx_q <= '0;
            else if (out_fire)      idx_q <= last_idx ? '0 : idx_q + 1'b1;
            if (state_q == S_FETCH)     wcnt_q <= '0;
            else if (state_q == S_WAIT) wcnt_q <= wcnt_q + 1'b1;
            if (wait_last) bias_q   <= bias_data;
            if (acc_fire)  out_data <= res;
        end
    end

endmodule

// File: doc/fc2_bias_add.md
# fc2_bias_add

Bias-consuming end of the FC2 bias interface. Drives the one-cycle read-enable pulses that step the FC2 bias ROM reader, captures each 8-bit bias word after ROM latency, adds it to the matching FC2 accumulator result, then requantises and saturates to a signed 8-bit output. Sits between the FC2 MAC array, the bias ROM reader and the output/argmax stage.

## Interface
- NUM_OUT, 10, FC2 output neurons per inference (= bias words consumed per inference)
- ACC_W, 24, signed accumulator width
- ROM_LAT, 1, cycles from the end of the enable pulse to valid bias data (≥1)
- BIAS_SHIFT, 4, left shift aligning bias to the accumulator scale
- OUT_SHIFT, 8, arithmetic right shift applied to the sum
- RELU, 0, 1 = clamp negative results to 0 before output

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low; also resets the bias reader's address counter
- start  in  1  begin one inference (NUM_OUT neurons); honoured only in IDLE
- bias_en  out  1  read enable to the bias reader; exactly one cycle high per neuron
- bias_data  in  8  signed bias word from the reader
- acc_valid  in  1  accumulator word valid
- acc_data  in  ACC_W  signed accumulator for the current neuron
- acc_ready  out  1  block accepts acc_data this cycle
- out_valid  out  1  out_data valid
- out_data  out  8  signed requantised result
- out_ready  in  1  downstream accepts out_data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after final output handshake

## Operation
- The bias reader advances its address on each falling edge of bias_en, with no rewind. Pulse k therefore reads bias k. Exactly NUM_OUT pulses are issued per inference, never more or fewer. Only rst_n realigns the reader.
- FSM states: IDLE, FETCH, WAIT, ACC, OUT.
  - IDLE: idx=0. On start → FETCH.
  - FETCH: bias_en=1 for this single cycle → WAIT.
  - WAIT: counts ROM_LAT cycles. On the last WAIT cycle edge, bias_data is registered into bias_q → ACC.
  - ACC: acc_ready=1. On acc_valid&acc_ready, compute the result and register it into out_data → OUT. acc_data presented in any other state is not consumed.
  - OUT: out_valid=1. out_data is held stable until out_ready.
    - On handshake with idx=NUM_OUT-1: → IDLE, done=1 for one cycle, idx=0.
    - Otherwise: idx+1, → FETCH.
- start outside IDLE is ignored. start in the same cycle as done has no effect; it must be reissued once IDLE.
- Arithmetic:
  - sum = sext(acc_data, ACC_W+9) + (sext(bias_q) <<< BIAS_SHIFT), computed at full width with no overflow.
  - q = sum >>> OUT_SHIFT (floor; no rounding).
  - If RELU and q<0, then q=0.
  - Saturate to [-128, 127].
- Reset mid-operation: all state returns to IDLE immediately. Any partial inference is discarded and no done is produced.

## Timing
- Reset values: bias_en=0, acc_ready=0, out_valid=0, out_data=0, busy=0, done=0, idx=0, bias_q=0.
- All outputs are registered. None depends combinationally on inputs.
- With start at edge 0 (ROM_LAT=1, acc_valid held high, out_ready held high):
  - FETCH during cycle 1 (bias_en high).
  - WAIT cycle 2; bias captured at the end of cycle 2.
  - ACC cycle 3; acc accepted at the end of cycle 3.
  - out_valid high in cycle 4.
  - Next FETCH in cycle 5.
- Per-neuron period = 4+ROM_LAT-1 cycles, plus any acc_valid or out_ready stall.
- done is asserted in the cycle after the last OUT handshake, concurrent with busy=0.
- bias_en is never high on two consecutive cycles. It is low in every cycle outside FETCH.

## Test plan
- Basic: ROM_LAT=1, bias=5, acc=1000 → sum 1080, out_data=4. Check bias_en high only in cycle 1 and out_valid in cycle 4.
- Saturation: acc=100000, bias=5 → 127. acc=-100000, bias=-3 → sum -100048 → -391 → -128. With RELU=1, the second case gives 0.
- Full inference, NUM_OUT=10, reader ROM holding 0..9:
  - Expect exactly 10 bias_en pulses.
  - Bias k pairs with acc k.
  - done pulses once after the 10th output, then busy=0.
- Backpressure and stalls:
  - Hold out_ready=0 for 7 cycles: out_data stays constant, no new bias_en pulse.
  - Hold acc_valid low for 5 cycles in ACC: acc_ready stays high, no progress.
  - Both cases: output values are unchanged.
- start while busy → ignored. Pulse count stays 10 and idx does not restart.
- Reset at neuron 4: all outputs return to reset values at once and no done is produced. A new start then reads bias 0 first, confirming realignment. Repeat with ROM_LAT=3 and check a 3-cycle WAIT.
